// File: rtl/lut_neuron_bank.sv
// Bank of NEURONS runtime-loadable lookup-table neurons behind a 2-stage valid/ready pipeline.
// Optional feature macro: LUT_PARITY_EN (per-entry even parity plus sticky parity_err output).

module lut_neuron_bank #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int NEURONS  = 4,
    parameter int NIDX_W   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NEURONS*IN_BITS-1:0]  in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NEURONS*OUT_BITS-1:0] out_data,
    input  logic                        cfg_we,
    output logic                        cfg_ready,
    input  logic [NIDX_W-1:0]           cfg_neuron,
    input  logic [IN_BITS-1:0]          cfg_addr,
    input  logic [OUT_BITS-1:0]         cfg_data,
    output logic                        init_done
`ifdef LUT_PARITY_EN
    ,
    output logic                        parity_err
`endif
);

    localparam int DEPTH = 1 << IN_BITS;
`ifdef LUT_PARITY_EN
    localparam int ENT_W = OUT_BITS + 1;
`else
    localparam int ENT_W = OUT_BITS;
`endif

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [IN_BITS-1:0]   cnt_q, cnt_d;
    logic                 run;

    // Tables live in distributed RAM: no reset, the INIT sweep clears them instead.
    logic [ENT_W-1:0]     mem_q [NEURONS][DEPTH];

    logic [NEURONS-1:0]   wr_en;
    logic [IN_BITS-1:0]   wr_addr;
    logic [ENT_W-1:0]     wr_ent;

    logic [NEURONS-1:0][ENT_W-1:0] rd_ent;
    logic [NEURONS*OUT_BITS-1:0]   lookup;

    logic                        s1_valid_q, s1_valid_d;
    logic [NEURONS*IN_BITS-1:0]  s1_addr_q, s1_addr_d;
    logic                        s2_valid_q, s2_valid_d;
    logic [NEURONS*OUT_BITS-1:0] s2_data_q, s2_data_d;
    logic                        s1_advance;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + IN_BITS'(1);
                if (&cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run       = (state_q == ST_RUN);
    assign cfg_ready = run;
    assign init_done = run;

    // While sweeping, every neuron clears entry cnt_q; afterwards only the config port writes.
    always_comb begin
        wr_en   = '0;
        wr_addr = cnt_q;
        wr_ent  = '0;
        if (!run) begin
            wr_en = '1;
        end else if (cfg_we) begin
            wr_addr = cfg_addr;
`ifdef LUT_PARITY_EN
            wr_ent  = {^cfg_data, cfg_data};
`else
            wr_ent  = cfg_data;
`endif
            for (int k = 0; k < NEURONS; k++) begin
                if (cfg_neuron == NIDX_W'(k)) begin
                    wr_en[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NEURONS; k++) begin
            if (wr_en[k]) begin
                mem_q[k][wr_addr] <= wr_ent;
            end
        end
    end

    // Asynchronous read of the S1 addresses; a same-edge write is not yet visible here.
    always_comb begin
        rd_ent = '0;
        lookup = '0;
        for (int k = 0; k < NEURONS; k++) begin
            rd_ent[k] = mem_q[k][s1_addr_q[k*IN_BITS +: IN_BITS]];
            lookup[k*OUT_BITS +: OUT_BITS] = rd_ent[k][OUT_BITS-1:0];
        end
    end

    assign s1_advance = !s2_valid_q || out_ready;
    assign in_ready   = run && (!s1_valid_q || s1_advance);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_addr_d = in_data;
            end
        end
        if (s1_advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = lookup;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;

`ifdef LUT_PARITY_EN
    logic [NEURONS-1:0] par_bad;
    logic               perr_q, perr_d;

    always_comb begin
        par_bad = '0;
        for (int k = 0; k < NEURONS; k++) begin
            par_bad[k] = ^rd_ent[k];
        end
    end

    // Sticky: any bad entry loaded into S2 latches the error until reset.
    always_comb begin
        perr_d = perr_q;
        if (s1_advance && s1_valid_q && (|par_bad)) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_lut_neuron_bank.sv
// Self-checking bench for lut_neuron_bank: scoreboard of expected vectors plus a 3-neuron
// instance for out-of-range config writes.

module tb_lut_neuron_bank;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 1;
    localparam int NEURONS  = 4;
    localparam int NIDX_W   = 2;
    localparam int DEPTH    = 256;
    localparam int VW       = NEURONS * IN_BITS;
    localparam int OW       = NEURONS * OUT_BITS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [VW-1:0] inData = '0;
    logic          outValid;
    logic          outReady = 1'b1;
    logic [OW-1:0] outData;
    logic          cfgWe = 1'b0;
    logic          cfgReady;
    logic [NIDX_W-1:0]  cfgNeuron = '0;
    logic [IN_BITS-1:0] cfgAddr = '0;
    logic [OUT_BITS-1:0] cfgData = '0;
    logic          initDone;

    logic          d3InValid = 1'b0;
    logic          d3InReady;
    logic [11:0]   d3InData = '0;
    logic          d3OutValid;
    logic          d3OutReady = 1'b1;
    logic [2:0]    d3OutData;
    logic          d3CfgWe = 1'b0;
    logic          d3CfgReady;
    logic [1:0]    d3CfgNeuron = '0;
    logic [3:0]    d3CfgAddr = '0;
    logic [0:0]    d3CfgData = '0;
    logic          d3InitDone;
`ifdef LUT_PARITY_EN
    logic          parityErr;
    logic          d3ParityErr;
`endif

    int nChecks = 0;
    int nFails  = 0;
    int rxCount = 0;
    int stallChecks = 0;

    logic [OW-1:0]       sbQ[$];
    logic [OUT_BITS-1:0] model [NEURONS][DEPTH];
    logic                holdValid = 1'b0;
    logic [OW-1:0]       holdData = '0;

    always #5 clk = ~clk;

    lut_neuron_bank #(
        .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .NEURONS(NEURONS), .NIDX_W(NIDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady), .in_data(inData),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData),
        .cfg_we(cfgWe), .cfg_ready(cfgReady), .cfg_neuron(cfgNeuron),
        .cfg_addr(cfgAddr), .cfg_data(cfgData), .init_done(initDone)
`ifdef LUT_PARITY_EN
        , .parity_err(parityErr)
`endif
    );

    lut_neuron_bank #(
        .IN_BITS(4), .OUT_BITS(1), .NEURONS(3), .NIDX_W(2)
    ) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(d3InValid), .in_ready(d3InReady), .in_data(d3InData),
        .out_valid(d3OutValid), .out_ready(d3OutReady), .out_data(d3OutData),
        .cfg_we(d3CfgWe), .cfg_ready(d3CfgReady), .cfg_neuron(d3CfgNeuron),
        .cfg_addr(d3CfgAddr), .cfg_data(d3CfgData), .init_done(d3InitDone)
`ifdef LUT_PARITY_EN
        , .parity_err(d3ParityErr)
`endif
    );

    function automatic logic [OW-1:0] expectedOut(input logic [VW-1:0] v);
        logic [OW-1:0] e;
        e = '0;
        for (int k = 0; k < NEURONS; k++) begin
            e[k*OUT_BITS +: OUT_BITS] = model[k][v[k*IN_BITS +: IN_BITS]];
        end
        return e;
    endfunction

    // Negedge monitor: handshakes seen here complete at the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            sbQ.delete();
            holdValid = 1'b0;
            for (int k = 0; k < NEURONS; k++) begin
                for (int a = 0; a < DEPTH; a++) begin
                    model[k][a] = '0;
                end
            end
        end else begin
            if (holdValid) begin
                nChecks++;
                stallChecks++;
                if (outValid !== 1'b1 || outData !== holdData) begin
                    nFails++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%h, expected valid=1 data=%h",
                             outValid, outData, holdData);
                end
            end
            holdValid = outValid && !outReady;
            holdData  = outData;
            if (outValid === 1'b1 && outReady) begin
                nChecks++;
                rxCount++;
                if (sbQ.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no output", outData);
                end else begin
                    logic [OW-1:0] exp;
                    exp = sbQ.pop_front();
                    if (outData !== exp) begin
                        nFails++;
                        $display("[TB] FAIL scoreboard: got %h expected %h", outData, exp);
                    end
                end
            end
            if (cfgWe && cfgReady === 1'b1 && cfgNeuron < NEURONS) begin
                model[cfgNeuron][cfgAddr] = cfgData;
            end
            if (inValid && inReady === 1'b1) begin
                sbQ.push_back(expectedOut(inData));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [VW-1:0] v);
        bit acc;
        acc = 1'b0;
        inValid = 1'b1;
        inData  = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = (inReady === 1'b1);
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL send_timeout: got in_ready=0 for 200 cycles, expected acceptance");
        end
    endtask

    task automatic cfg_write(input logic [1:0] n, input logic [7:0] a, input logic d);
        cfgWe = 1'b1;
        cfgNeuron = n;
        cfgAddr = a;
        cfgData = d;
        nChecks++;
        if (cfgReady !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL cfg_ready: got %b expected 1", cfgReady);
        end
        tick();
        cfgWe = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sbQ.size() == 0 && outValid !== 1'b1) break;
            tick();
        end
        nChecks++;
        if (sbQ.size() != 0) begin
            nFails++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", sbQ.size());
        end
    endtask

    task automatic wait_init(output int cycles, output bit leak);
        cycles = -1;
        leak = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (inReady !== 1'b0 || cfgReady !== 1'b0) leak = 1'b1;
            tick();
            if (initDone === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        bit leak;
        rst = 1'b0;
        inValid = 1'b1;
        repeat (3) tick();
        nChecks += 5;
        if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL rst_out_valid: got %b expected 0", outValid); end
        if (outData !== '0) begin nFails++; $display("[TB] FAIL rst_out_data: got %h expected 0", outData); end
        if (initDone !== 1'b0) begin nFails++; $display("[TB] FAIL rst_init_done: got %b expected 0", initDone); end
        if (inReady !== 1'b0) begin nFails++; $display("[TB] FAIL rst_in_ready: got %b expected 0", inReady); end
        if (cfgReady !== 1'b0) begin nFails++; $display("[TB] FAIL rst_cfg_ready: got %b expected 0", cfgReady); end
        rst = 1'b1;
        wait_init(cyc, leak);
        inValid = 1'b0;
        nChecks += 3;
        if (cyc != 256) begin nFails++; $display("[TB] FAIL init_length: got %0d cycles expected 256", cyc); end
        if (leak) begin nFails++; $display("[TB] FAIL init_ready_leak: got ready=1 during INIT, expected 0"); end
        if (d3InitDone !== 1'b1) begin nFails++; $display("[TB] FAIL d3_init_done: got %b expected 1", d3InitDone); end
    endtask

    task automatic test_init_zero();
        int rxStart;
        rxStart = rxCount;
        outReady = 1'b1;
        for (int n = 0; n < 6; n++) send_vec($urandom());
        inValid = 1'b0;
        drain();
        nChecks++;
        if (rxCount - rxStart != 6) begin
            nFails++;
            $display("[TB] FAIL init_zero_count: got %0d outputs expected 6", rxCount - rxStart);
        end
    endtask

    task automatic test_single_lookup();
        outReady = 1'b1;
        cfg_write(2'd1, 8'h40, 1'b1);
        send_vec(32'h0000_4000);
        inValid = 1'b0;
        nChecks++;
        if (outValid !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL latency_early: got out_valid=%b one cycle after accept, expected 0", outValid);
        end
        tick();
        nChecks++;
        if (outValid !== 1'b1 || outData !== 4'b0010) begin
            nFails++;
            $display("[TB] FAIL single_lookup: got valid=%b data=%b expected valid=1 data=0010", outValid, outData);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] vecs [10];
        int rxStart;
        int stallStart;
        for (int k = 0; k < NEURONS; k++) begin
            for (int j = 0; j < 4; j++) begin
                cfg_write(2'(k), 8'h10 + 8'(j), 1'((k + j) % 2));
            end
        end
        for (int n = 0; n < 10; n++) begin
            for (int k = 0; k < NEURONS; k++) begin
                vecs[n][k*IN_BITS +: IN_BITS] = 8'h10 + 8'($urandom_range(0, 3));
            end
        end
        rxStart = rxCount;
        stallStart = stallChecks;
        fork
            begin
                for (int n = 0; n < 10; n++) send_vec(vecs[n]);
                inValid = 1'b0;
            end
            begin
                for (int p = 0; p < 300 && rxCount < rxStart + 10; p++) begin
                    outReady = (p % 3 == 0);
                    tick();
                end
                outReady = 1'b1;
            end
        join
        drain();
        nChecks += 2;
        if (rxCount - rxStart != 10) begin
            nFails++;
            $display("[TB] FAIL b2b_count: got %0d outputs expected 10", rxCount - rxStart);
        end
        if (stallChecks == stallStart) begin
            nFails++;
            $display("[TB] FAIL b2b_stall: got 0 stalled cycles expected at least 1");
        end
    endtask

    task automatic test_collision();
        outReady = 1'b1;
        cfg_write(2'd0, 8'd5, 1'b0);
        send_vec(32'h0000_0005);
        inValid = 1'b0;
        cfgWe = 1'b1;
        cfgNeuron = 2'd0;
        cfgAddr = 8'd5;
        cfgData = 1'b1;
        tick();
        cfgWe = 1'b0;
        nChecks++;
        if (outValid !== 1'b1 || outData !== 4'b0000) begin
            nFails++;
            $display("[TB] FAIL collision_old: got valid=%b data=%b expected valid=1 data=0000", outValid, outData);
        end
        send_vec(32'h0000_0005);
        inValid = 1'b0;
        tick();
        nChecks++;
        if (outValid !== 1'b1 || outData !== 4'b0001) begin
            nFails++;
            $display("[TB] FAIL collision_new: got valid=%b data=%b expected valid=1 data=0001", outValid, outData);
        end
        drain();
    endtask

    task automatic test_cfg_drop();
        d3CfgWe = 1'b1;
        d3CfgNeuron = 2'd3;
        d3CfgAddr = 4'h9;
        d3CfgData = 1'b1;
        nChecks++;
        if (d3CfgReady !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL drop_cfg_ready: got %b expected 1", d3CfgReady);
        end
        tick();
        d3CfgNeuron = 2'd2;
        d3CfgAddr = 4'h4;
        tick();
        d3CfgWe = 1'b0;
        d3OutReady = 1'b1;
        d3InValid = 1'b1;
        d3InData = 12'h999;
        tick();
        d3InData = 12'h444;
        tick();
        nChecks++;
        if (d3OutValid !== 1'b1 || d3OutData !== 3'b000) begin
            nFails++;
            $display("[TB] FAIL drop_unchanged: got valid=%b data=%b expected valid=1 data=000", d3OutValid, d3OutData);
        end
        d3InValid = 1'b0;
        tick();
        nChecks++;
        if (d3OutValid !== 1'b1 || d3OutData !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL drop_control: got valid=%b data=%b expected valid=1 data=100", d3OutValid, d3OutData);
        end
    endtask

`ifdef LUT_PARITY_EN
    task automatic test_parity();
        nChecks++;
        if (parityErr !== 1'b0) begin nFails++; $display("[TB] FAIL parity_clean: got %b expected 0", parityErr); end
        dut.mem_q[2][7] = dut.mem_q[2][7] ^ 2'b01;
        model[2][7] = ~model[2][7];
        outReady = 1'b1;
        send_vec(32'h0007_0000);
        inValid = 1'b0;
        drain();
        nChecks++;
        if (parityErr !== 1'b1) begin nFails++; $display("[TB] FAIL parity_detect: got %b expected 1", parityErr); end
        repeat (5) tick();
        nChecks++;
        if (parityErr !== 1'b1) begin nFails++; $display("[TB] FAIL parity_sticky: got %b expected 1", parityErr); end
    endtask
`endif

    task automatic test_reset_midstream();
        int cyc;
        bit leak;
        outReady = 1'b0;
        send_vec(32'h0000_4000);
        send_vec(32'h0000_0005);
        inValid = 1'b0;
        nChecks++;
        if (outValid !== 1'b1) begin nFails++; $display("[TB] FAIL mid_pre_valid: got %b expected 1", outValid); end
        rst = 1'b0;
        #1;
        nChecks += 3;
        if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_out_valid: got %b expected 0", outValid); end
        if (outData !== '0) begin nFails++; $display("[TB] FAIL mid_out_data: got %h expected 0", outData); end
        if (inReady !== 1'b0) begin nFails++; $display("[TB] FAIL mid_in_ready: got %b expected 0", inReady); end
        outReady = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        repeat (100) tick();
        rst = 1'b0;
        tick();
        tick();
        nChecks++;
        if (initDone !== 1'b0) begin nFails++; $display("[TB] FAIL sweep_reset: got init_done=%b expected 0", initDone); end
        rst = 1'b1;
        wait_init(cyc, leak);
        nChecks += 2;
        if (cyc != 256) begin nFails++; $display("[TB] FAIL reinit_length: got %0d cycles expected 256", cyc); end
        if (leak) begin nFails++; $display("[TB] FAIL reinit_ready_leak: got ready=1 during INIT, expected 0"); end
`ifdef LUT_PARITY_EN
        nChecks++;
        if (parityErr !== 1'b0) begin nFails++; $display("[TB] FAIL parity_reset: got %b expected 0", parityErr); end
`endif
        send_vec(32'h0000_4005);
        inValid = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_single_lookup();
        test_back_to_back();
        test_collision();
        test_cfg_drop();
`ifdef LUT_PARITY_EN
        test_parity();
`endif
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
